pattern_gen_multi: RTL and testbench

Parametrised, multi-mode successor to the 8-bit pattern generator. Produces a WIDTH-bit pattern on `out` and advances one pattern step every DIV enabled clock cycles. The mode is selectable at run time: walking-one, bounce (ping-pong), Johnson, or binary count; with the optional macro, the count mode becomes an LFSR. Used as a stimulus/LED/scan-pattern source; a one-cycle `wrap` pulse marks the start of each new pattern period.

---
 rtl/pattern_gen_multi.sv | 133 +++++++++++++
 tb/tb_pattern_gen_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_multi.sv
// Multi-mode WIDTH-bit pattern generator: walk, bounce, Johnson, count.
// Define PATTERN_GEN_LFSR_EN to turn mode 3 into a Galois LFSR.
module pattern_gen_multi #(
  parameter int              WIDTH = 8,
  parameter int              DIV   = 1,
  parameter logic [WIDTH-1:0] SEED = 1,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_ld,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    WALK   = 2'd0,
    BOUNCE = 2'd1,
    JOHN   = 2'd2,
    CNT    = 2'd3
  } mode_t;

  mode_t           mode_r;
  logic [CW-1:0]   div_cnt;
  logic            dir;
  logic [WIDTH-1:0] nxt;
  logic            ndir;
  logic            nwrap;
  logic            step;

`ifndef PATTERN_GEN_LFSR_EN
  // Seed and taps only matter in the LFSR build.
  logic unused_cfg;
  assign unused_cfg = ^{SEED, TAPS};
`endif

  function automatic logic [WIDTH-1:0] start_val(input logic [1:0] m);
    logic [WIDTH-1:0] v;
    unique case (m)
      2'd0, 2'd1: v = WIDTH'(1);
      2'd2:       v = '0;
`ifdef PATTERN_GEN_LFSR_EN
      2'd3:       v = SEED;
`else
      2'd3:       v = '0;
`endif
    endcase
    return v;
  endfunction

  assign step = en && (div_cnt == LAST);

  // Next pattern value, direction and wrap flag for one step.
  always_comb begin
    nxt   = out;
    ndir  = dir;
    nwrap = 1'b0;
    unique case (mode_r)
      WALK: begin
        if (!$onehot(out)) begin
          nxt = WIDTH'(1);
        end else begin
          nxt   = {out[WIDTH-2:0], out[WIDTH-1]};
          nwrap = out[WIDTH-1];
        end
      end
      BOUNCE: begin
        if (!$onehot(out) || (!dir && out[WIDTH-1]) ||
            (dir && out[0])) begin
          nxt  = WIDTH'(1);
          ndir = 1'b0;
        end else if (!dir) begin
          nxt  = out << 1;
          ndir = nxt[WIDTH-1];
        end else begin
          nxt   = out >> 1;
          nwrap = (nxt == WIDTH'(1));
          ndir  = !nwrap;
        end
      end
      JOHN: begin
        // Legal Johnson codes have at most one 0/1 boundary.
        if ($countones(out[WIDTH-1:1] ^ out[WIDTH-2:0]) > 1) begin
          nxt = '0;
        end else begin
          nxt   = {out[WIDTH-2:0], ~out[WIDTH-1]};
          nwrap = (nxt == '0);
        end
      end
      CNT: begin
`ifdef PATTERN_GEN_LFSR_EN
        if (out == '0) nxt = SEED;
        else nxt = (out >> 1) ^ (out[0] ? TAPS : '0);
        nwrap = (nxt == SEED);
`else
        nxt   = out + WIDTH'(1);
        nwrap = (nxt == '0);
`endif
      end
    endcase
  end

  // State register: load beats enable; divider gates each step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= WIDTH'(1);
      mode_r  <= WALK;
      div_cnt <= '0;
      dir     <= 1'b0;
      wrap    <= 1'b0;
    end else if (mode_ld) begin
      mode_r  <= mode_t'(mode);
      out     <= start_val(mode);
      div_cnt <= '0;
      dir     <= 1'b0;
      wrap    <= 1'b0;
    end else if (step) begin
      out     <= nxt;
      dir     <= ndir;
      wrap    <= nwrap;
      div_cnt <= '0;
    end else begin
      if (en) div_cnt <= div_cnt + CW'(1);
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Scoreboard bench for pattern_gen_multi.
// Covers all modes, divider, hold, async reset, load priority.
module tb_pattern_gen_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       en1, ld1, en3, ld3;
  logic [1:0] md1, md3;
  logic [7:0] out1, out3;
  logic       w1, w3;

  logic [8:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  pattern_gen_multi #(.WIDTH(8), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .en(en1), .mode_ld(ld1),
    .mode(md1), .out(out1), .wrap(w1)
  );

  pattern_gen_multi #(.WIDTH(8), .DIV(3)) u3 (
    .clk(clk), .rst(rst), .en(en3), .mode_ld(ld3),
    .mode(md3), .out(out3), .wrap(w3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] walk(input int k);
    return 8'(1 << (k % 8));
  endfunction

  function automatic logic [7:0] bounce(input int k);
    int i;
    i = k % 14;
    return (i < 8) ? 8'(1 << i) : 8'(1 << (14 - i));
  endfunction

  function automatic logic [7:0] johnson(input int k);
    int i;
    i = k % 16;
    if (i <= 8) return 8'((1 << i) - 1);
    return 8'((255 << (i - 8)) & 255);
  endfunction

  task automatic test_reset();
    logic [8:0] e;
    rst = 1'b1;
    en1 = 1'b0; ld1 = 1'b0; md1 = 2'd0;
    en3 = 1'b0; ld3 = 1'b0; md3 = 2'd0;
    tick(); tick();
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h01});
    e = exp_q.pop_front();
    tests++;
    if ({w1, out1} !== e) begin
      fails++;
      $display("FAIL reset_u1 got=%h want=%h", {w1, out1}, e);
    end
    e = exp_q.pop_front();
    tests++;
    if ({w3, out3} !== e) begin
      fails++;
      $display("FAIL reset_u3 got=%h want=%h", {w3, out3}, e);
    end
    rst = 1'b0;
  endtask

  task automatic test_walk();
    logic [8:0] e;
    en1 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back({(k % 8) == 0, walk(k)});
      tick();
      e = exp_q.pop_front();
      tests++;
      if ({w1, out1} !== e) begin
        fails++;
        $display("FAIL walk k=%0d got=%h want=%h", k, {w1, out1}, e);
      end
    end
    en1 = 1'b0;
  endtask

  task automatic load1(input logic [1:0] m, input logic [7:0] sv);
    logic [8:0] e;
    ld1 = 1'b1; md1 = m; en1 = 1'b1;
    exp_q.push_back({1'b0, sv});
    tick();
    ld1 = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if ({w1, out1} !== e) begin
      fails++;
      $display("FAIL load m=%0d got=%h want=%h", m, {w1, out1}, e);
    end
  endtask

  task automatic test_bounce();
    logic [8:0] e;
    load1(2'd1, 8'h01);
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back({(k % 14) == 0, bounce(k)});
      tick();
      e = exp_q.pop_front();
      tests++;
      if ({w1, out1} !== e) begin
        fails++;
        $display("FAIL bounce k=%0d got=%h want=%h", k, {w1, out1}, e);
      end
    end
    en1 = 1'b0;
  endtask

  task automatic test_johnson();
    logic [8:0] e;
    load1(2'd2, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      exp_q.push_back({(k % 16) == 0, johnson(k)});
      tick();
      e = exp_q.pop_front();
      tests++;
      if ({w1, out1} !== e) begin
        fails++;
        $display("FAIL johnson k=%0d got=%h want=%h", k, {w1, out1}, e);
      end
    end
    en1 = 1'b0;
  endtask

  task automatic test_div_hold();
    logic [8:0] e;
    int n;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if ((n == 4 || n == 24) && en3) en3 = 1'b0;
      else if (!en3 && c > 0 && c % 40 == 0) en3 = 1'b1;
      en3 = !((c >= 4 && c < 9) || (c >= 29 && c < 34));
      if (en3) n++;
      exp_q.push_back({en3 && (n % 3 == 0) && ((n / 3) % 8 == 0),
                       walk(n / 3)});
      tick();
      e = exp_q.pop_front();
      tests++;
      if ({w3, out3} !== e) begin
        fails++;
        $display("FAIL div c=%0d n=%0d got=%h want=%h",
                 c, n, {w3, out3}, e);
      end
    end
    en3 = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [8:0] e;
    load1(2'd1, 8'h01);
    for (int k = 1; k <= 9; k++) begin
      exp_q.push_back({1'b0, bounce(k)});
      tick();
      e = exp_q.pop_front();
      tests++;
      if ({w1, out1} !== e) begin
        fails++;
        $display("FAIL pre_rst k=%0d got=%h want=%h", k, {w1, out1}, e);
      end
    end
    #2 rst = 1'b1;
    exp_q.push_back({1'b0, 8'h01});
    #1;
    e = exp_q.pop_front();
    tests++;
    if ({w1, out1} !== e) begin
      fails++;
      $display("FAIL async_rst got=%h want=%h", {w1, out1}, e);
    end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back({1'b0, walk(k)});
      tick();
      e = exp_q.pop_front();
      tests++;
      if ({w1, out1} !== e) begin
        fails++;
        $display("FAIL post_rst k=%0d got=%h want=%h", k, {w1, out1}, e);
      end
    end
  endtask

  task automatic test_ld_priority();
    logic [8:0] e;
    load1(2'd2, 8'h00);
    en1 = 1'b0;
    en3 = 1'b1;
    tick(); tick();
    ld3 = 1'b1; md3 = 2'd2;
    exp_q.push_back({1'b0, 8'h00});
    tick();
    ld3 = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if ({w3, out3} !== e) begin
      fails++;
      $display("FAIL ld_prio got=%h want=%h", {w3, out3}, e);
    end
    for (int c = 1; c <= 3; c++) begin
      exp_q.push_back({1'b0, (c == 3) ? 8'h01 : 8'h00});
      tick();
      e = exp_q.pop_front();
      tests++;
      if ({w3, out3} !== e) begin
        fails++;
        $display("FAIL ld_div c=%0d got=%h want=%h", c, {w3, out3}, e);
      end
    end
    en3 = 1'b0;
  endtask

  task automatic test_count();
    logic [8:0] e;
`ifdef PATTERN_GEN_LFSR_EN
    logic [7:0] m;
    logic [7:0] ref_v[5];
    ref_v = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    load1(2'd3, 8'h01);
    m = 8'h01;
    for (int k = 1; k <= 255; k++) begin
      m = (m >> 1) ^ (m[0] ? 8'hB8 : 8'h00);
      exp_q.push_back({k == 255, m});
      tick();
      e = exp_q.pop_front();
      tests++;
      if ({w1, out1} !== e || out1 === 8'h00) begin
        fails++;
        $display("FAIL lfsr k=%0d got=%h want=%h", k, {w1, out1}, e);
      end
      if (k <= 5) begin
        tests++;
        if (out1 !== ref_v[k-1]) begin
          fails++;
          $display("FAIL lfsr_tab k=%0d got=%h want=%h",
                   k, out1, ref_v[k-1]);
        end
      end
    end
`else
    load1(2'd3, 8'h00);
    for (int k = 1; k <= 258; k++) begin
      exp_q.push_back({(k % 256) == 0, 8'(k % 256)});
      tick();
      e = exp_q.pop_front();
      tests++;
      if ({w1, out1} !== e) begin
        fails++;
        $display("FAIL count k=%0d got=%h want=%h", k, {w1, out1}, e);
      end
    end
`endif
    en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_walk();
    test_bounce();
    test_johnson();
    test_div_hold();
    test_async_reset();
    test_ld_priority();
    test_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
